secp256k1_mul_scheduler: RTL and testbench
==========================================

SECP256K1_MUL_SCHEDULER -- requirements
Module: secp256k1_mul_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 5000000, maximum cycles to wait for multiplier done.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  N_REQ  per-requester request valid.
REQ-006 req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-007 req_k  input  N_REQ*256  scalars, requester i at bits [256*i +: 256].
REQ-008 req_px, req_py  input  N_REQ*256 each  base points, same packing.
REQ-009 req_use_g  input  N_REQ  select generator instead of px/py.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  result consumer ready.
REQ-012 rsp_id  output  3  index of requester owning the result.
REQ-013 rsp_qx, rsp_qy  output  256 each  result affine coordinates.
REQ-014 rsp_inf  output  1  result is point at infinity.
REQ-015 rsp_timeout  output  1  multiplier timed out; qx/qy/inf invalid.
REQ-016 mul_start, mul_k, mul_px, mul_py, mul_use_g  output  1/256/256/256/1  drive wNAF multiplier.
REQ-017 mul_qx, mul_qy, mul_done, mul_inf  input  256/256/1/1  multiplier results.
REQ-018 mul_rst_n  output  1  multiplier reset, active-low.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-021 IDLE: round-robin grant among req_valid, starting search at rr_ptr; req_ready[g]=1 only for granted g, combinationally.
REQ-022 On req_valid[g]&&req_ready[g]: latch operands and id g into registers, rr_ptr<=(g+1) mod N_REQ, go ISSUE.
REQ-023 No request valid: stay IDLE, rr_ptr unchanged.
REQ-024 ISSUE: mul_start=1 for exactly one cycle, mul_k/px/py/use_g driven from latched registers continuously from ISSUE through WAIT; go WAIT; clear cycle counter.
REQ-025 mul_done sampled only in WAIT; done high during ISSUE is ignored.
REQ-026 WAIT with mul_done=1: capture mul_qx, mul_qy, mul_inf into rsp registers, rsp_timeout=0, go RESP.
REQ-027 WAIT counter increments each cycle; when counter reaches TIMEOUT-1 and mul_done=0: rsp_qx=rsp_qy=0, rsp_inf=0, rsp_timeout=1, go RESP, pulse mul_rst_n low for exactly the next cycle.
REQ-028 mul_done and timeout in the same cycle: done wins, no timeout.
REQ-029 RESP: rsp_valid=1, all rsp_* stable until rsp_valid&&rsp_ready; then IDLE.
REQ-030 No req_ready asserted outside IDLE; a new grant occurs no earlier than the cycle after the response handshake.
REQ-031 Minimum request-to-response latency: accept cycle + ISSUE + 1 WAIT cycle + RESP = rsp_valid 3 cycles after accept.
REQ-032 Counter width is clog2(TIMEOUT)+1; no wrap-around permitted.

Reset
REQ-033 While rst_n=0 at a clock edge: state=IDLE, rr_ptr=0, counter=0, rsp_valid=0, rsp_timeout=0, rsp_inf=0, rsp_id=0, rsp_qx=rsp_qy=0, mul_start=0, latched operands=0, busy=0.
REQ-034 mul_rst_n is the AND of rst_n and the registered abort pulse; low whenever rst_n is low.
REQ-035 Reset asserted mid-operation discards the job: no response issued for it.

Structure
REQ-036 Shared package secp256k1_pkg holds CURVE_P, CURVE_N, GX, GY, and the scheduler state encoding.
REQ-037 Round-robin grant logic is a sub-module rr_arbiter (N_REQ requests, pointer in, one-hot grant out).

Verification
REQ-038 Single req0, k=1, use_g=1 -> rsp_id=0, rsp_qx=79BE667E...16F81798, rsp_qy=483ADA77...FB10D4B8, rsp_inf=0.
REQ-039 req0 k=2 and req2 k=3 raised in same cycle, rr_ptr=0 -> req0 served first (qx=C6047F94...5C709EE5), then req2 (qx=F9308A01...BCE036F9).
REQ-040 req1 k=0 -> rsp_id=1, rsp_inf=1, rsp_timeout=0.
REQ-041 Stub multiplier never raising done, TIMEOUT=100 -> rsp_valid with rsp_timeout=1 on the 101st cycle after ISSUE, mul_rst_n low exactly one cycle.
REQ-042 rsp_ready held low 10 cycles with req3 valid -> rsp_* stable, req_ready stays 0 until handshake.
REQ-043 rst_n low for one cycle during WAIT -> all outputs at reset values, no rsp_valid for the aborted job, next request served normally.

Source files
------------

// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 curve constants and the multiply scheduler state encoding.
package secp256k1_pkg;

    localparam logic [255:0] CURVE_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] CURVE_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [255:0] GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after ptr_i.
module rr_arbiter #(
    parameter int unsigned NReq = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [NReq-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NReq-1:0] grant_o
);

    logic [2*NReq-1:0] req2;
    logic              found;

    // Doubling the request vector turns the wrap-around search into a linear scan.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        req2    = {req_i, req_i};
        for (int unsigned i = 0; i < 2 * NReq; i++) begin
            if (!found && i >= 32'(ptr_i) && req2[i]) begin
                grant_o[i % NReq] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/secp256k1_mul_scheduler.sv
// Arbitrates scalar-multiply jobs from N_REQ requesters onto one wNAF multiplier, with timeout.
module secp256k1_mul_scheduler
    import secp256k1_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 5000000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [N_REQ*256-1:0] req_k_i,
    input  logic [N_REQ*256-1:0] req_px_i,
    input  logic [N_REQ*256-1:0] req_py_i,
    input  logic [N_REQ-1:0]     req_use_g_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [2:0]           rsp_id_o,
    output logic [255:0]         rsp_qx_o,
    output logic [255:0]         rsp_qy_o,
    output logic                 rsp_inf_o,
    output logic                 rsp_timeout_o,
    output logic                 mul_start_o,
    output logic [255:0]         mul_k_o,
    output logic [255:0]         mul_px_o,
    output logic [255:0]         mul_py_o,
    output logic                 mul_use_g_o,
    input  logic [255:0]         mul_qx_i,
    input  logic [255:0]         mul_qy_i,
    input  logic                 mul_done_i,
    input  logic                 mul_inf_i,
    output logic                 mul_rst_no,
    output logic                 busy_o
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    logic [1:0]      state_q, state_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [255:0]    k_q, k_d, px_q, px_d, py_q, py_d;
    logic            use_g_q, use_g_d;
    logic [2:0]      id_q, id_d;
    logic [2:0]      rsp_id_q, rsp_id_d;
    logic [255:0]    rsp_qx_q, rsp_qx_d, rsp_qy_q, rsp_qy_d;
    logic            rsp_inf_q, rsp_inf_d, rsp_to_q, rsp_to_d;
    logic            abort_q, abort_d;
    logic [N_REQ-1:0] grant;
    logic [PtrW-1:0]  gnt_idx;

    rr_arbiter #(
        .NReq (N_REQ),
        .PtrW (PtrW)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) gnt_idx = PtrW'(i);
        end
    end

    assign req_ready_o = (state_q == StIdle) ? grant : '0;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        px_d      = px_q;
        py_d      = py_q;
        use_g_d   = use_g_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        rsp_qx_d  = rsp_qx_q;
        rsp_qy_d  = rsp_qy_q;
        rsp_inf_d = rsp_inf_q;
        rsp_to_d  = rsp_to_q;
        abort_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (|(req_valid_i & req_ready_o)) begin
                    k_d      = req_k_i[256*gnt_idx +: 256];
                    px_d     = req_px_i[256*gnt_idx +: 256];
                    py_d     = req_py_i[256*gnt_idx +: 256];
                    use_g_d  = req_use_g_i[gnt_idx];
                    id_d     = 3'(gnt_idx);
                    rr_ptr_d = (gnt_idx == PtrW'(N_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // A completion in the final counted cycle still beats the timeout.
                if (mul_done_i) begin
                    rsp_qx_d  = mul_qx_i;
                    rsp_qy_d  = mul_qy_i;
                    rsp_inf_d = mul_inf_i;
                    rsp_to_d  = 1'b0;
                    rsp_id_d  = id_q;
                    state_d   = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    rsp_qx_d  = '0;
                    rsp_qy_d  = '0;
                    rsp_inf_d = 1'b0;
                    rsp_to_d  = 1'b1;
                    rsp_id_d  = id_q;
                    abort_d   = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            use_g_q   <= 1'b0;
            id_q      <= '0;
            rsp_id_q  <= '0;
            rsp_qx_q  <= '0;
            rsp_qy_q  <= '0;
            rsp_inf_q <= 1'b0;
            rsp_to_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            px_q      <= px_d;
            py_q      <= py_d;
            use_g_q   <= use_g_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            rsp_qx_q  <= rsp_qx_d;
            rsp_qy_q  <= rsp_qy_d;
            rsp_inf_q <= rsp_inf_d;
            rsp_to_q  <= rsp_to_d;
            abort_q   <= abort_d;
        end
    end

    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_id_o      = rsp_id_q;
    assign rsp_qx_o      = rsp_qx_q;
    assign rsp_qy_o      = rsp_qy_q;
    assign rsp_inf_o     = rsp_inf_q;
    assign rsp_timeout_o = rsp_to_q;
    assign mul_start_o   = (state_q == StIssue);
    assign mul_k_o       = k_q;
    assign mul_px_o      = px_q;
    assign mul_py_o      = py_q;
    assign mul_use_g_o   = use_g_q;
    assign mul_rst_no    = rst_ni & ~abort_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_secp256k1_mul_scheduler.sv
// Directed bench: stub multiplier, cycle-level job model and literal curve-point checks.
module tb_secp256k1_mul_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned TO = 100;
    localparam logic [255:0] G1X =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] G1Y =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] G2X =
        256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
    localparam logic [255:0] G2Y =
        256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
    localparam logic [255:0] G3X =
        256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
    localparam logic [255:0] G3Y =
        256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;

    typedef struct packed {
        logic         inf;
        logic [255:0] x;
        logic [255:0] y;
    } pt_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR-1:0]       req_valid, req_ready, req_use_g;
    logic [NR*256-1:0]   req_k, req_px, req_py;
    logic                rsp_valid, rsp_ready, rsp_inf, rsp_timeout;
    logic [2:0]          rsp_id;
    logic [255:0]        rsp_qx, rsp_qy;
    logic                mul_start, mul_use_g, mul_done, mul_inf, mul_rst_n, busy;
    logic [255:0]        mul_k, mul_px, mul_py, mul_qx, mul_qy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    secp256k1_mul_scheduler #(.N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_k_i(req_k), .req_px_i(req_px), .req_py_i(req_py), .req_use_g_i(req_use_g),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_qx_o(rsp_qx), .rsp_qy_o(rsp_qy), .rsp_inf_o(rsp_inf),
        .rsp_timeout_o(rsp_timeout),
        .mul_start_o(mul_start), .mul_k_o(mul_k), .mul_px_o(mul_px), .mul_py_o(mul_py),
        .mul_use_g_o(mul_use_g), .mul_qx_i(mul_qx), .mul_qy_i(mul_qy),
        .mul_done_i(mul_done), .mul_inf_i(mul_inf), .mul_rst_no(mul_rst_n), .busy_o(busy)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference results the stub multiplier returns; small multiples of G are real curve points.
    function automatic pt_t point_of(logic [255:0] k, logic use_g, logic [255:0] px,
                                     logic [255:0] py);
        pt_t p;
        p.inf = 1'b0;
        if (k == 256'd0) begin
            p.inf = 1'b1; p.x = '0; p.y = '0;
        end else if (use_g && k == 256'd1) begin
            p.x = G1X; p.y = G1Y;
        end else if (use_g && k == 256'd2) begin
            p.x = G2X; p.y = G2Y;
        end else if (use_g && k == 256'd3) begin
            p.x = G3X; p.y = G3Y;
        end else begin
            p.x = px + k * 256'd3; p.y = py ^ k;
        end
        return p;
    endfunction

    function automatic int rr_pick(logic [NR-1:0] v, int p);
        for (int i = 0; i < int'(NR); i++) begin
            if (v[(p + i) % int'(NR)]) return (p + i) % int'(NR);
        end
        return -1;
    endfunction

    // Stub multiplier: done arrives stub_lat cycles into WAIT, or never when stub_hang.
    int   stub_lat = 0;
    bit   stub_hang = 1'b0;
    logic spur_done = 1'b0;
    logic stub_done = 1'b0;
    int   pend = 0;
    pt_t  stub_pt = '0;
    logic [255:0] sk = '0, spx = '0, spy = '0;
    logic         sg = 1'b0;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (!mul_rst_n) begin
            pend <= 0;
        end else if (mul_start && !stub_hang) begin
            if (stub_lat == 0) begin
                stub_done <= 1'b1;
                stub_pt   <= point_of(mul_k, mul_use_g, mul_px, mul_py);
            end else begin
                pend <= stub_lat;
                sk <= mul_k; sg <= mul_use_g; spx <= mul_px; spy <= mul_py;
            end
        end else if (pend > 0) begin
            if (pend == 1) begin
                stub_done <= 1'b1;
                stub_pt   <= point_of(sk, sg, spx, spy);
            end
            pend <= pend - 1;
        end
    end

    assign mul_done = stub_done | spur_done;
    assign mul_qx   = stub_pt.x;
    assign mul_qy   = stub_pt.y;
    assign mul_inf  = stub_pt.inf;

    // Job-level model: age counts cycles since the accepting edge.
    bit   m_valid = 1'b0, m_idle = 1'b1, m_to = 1'b0;
    int   m_ptr = 0, m_age = 0, m_resp_age = 0, m_id = 0;
    logic [255:0] m_k = '0, m_px = '0, m_py = '0;
    logic m_g = 1'b0;

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_valid = 1'b1; m_idle = 1'b1; m_ptr = 0;
        end else if (m_valid) begin
            if (m_idle) begin
                g = rr_pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_idle = 1'b0; m_age = 1; m_id = g;
                    m_k = req_k[256*g +: 256]; m_px = req_px[256*g +: 256];
                    m_py = req_py[256*g +: 256]; m_g = req_use_g[g];
                    m_ptr = (g + 1) % int'(NR);
                    m_to = stub_hang;
                    m_resp_age = stub_hang ? int'(TO) + 2 : 3 + stub_lat;
                end
            end else if (m_age >= m_resp_age && rsp_ready) begin
                m_idle = 1'b1;
            end else begin
                m_age++;
            end
        end
    end

    int rl_cnt = 0;
    always @(negedge clk) begin
        logic [NR-1:0] exp_ready;
        bit exp_rv;
        pt_t ep;
        int g;
        if (rst_n && !mul_rst_n) rl_cnt++;
        if (m_valid) begin
            exp_ready = '0;
            if (m_idle) begin
                g = rr_pick(req_valid, m_ptr);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            exp_rv = !m_idle && m_age >= m_resp_age;
            check("busy", 256'(busy), 256'(!m_idle));
            check("req_ready", 256'(req_ready), 256'(exp_ready));
            check("rsp_valid", 256'(rsp_valid), 256'(exp_rv));
            check("mul_start", 256'(mul_start), 256'(!m_idle && m_age == 1));
            check("mul_rst_n", 256'(mul_rst_n),
                  256'(rst_n && !(!m_idle && m_to && m_age == m_resp_age)));
            if (!m_idle && m_age < m_resp_age) begin
                check("mul_k", mul_k, m_k);
                check("mul_px", mul_px, m_px);
                check("mul_use_g", 256'(mul_use_g), 256'(m_g));
            end
            if (exp_rv) begin
                ep = m_to ? '0 : point_of(m_k, m_g, m_px, m_py);
                check("rsp_id", 256'(rsp_id), 256'(m_id));
                check("rsp_qx", rsp_qx, ep.x);
                check("rsp_qy", rsp_qy, ep.y);
                check("rsp_inf", 256'(rsp_inf), 256'(ep.inf));
                check("rsp_timeout", 256'(rsp_timeout), 256'(m_to));
            end
        end
    end

    task automatic set_req(input int i, input logic [255:0] k, input logic g,
                           input logic [255:0] px, input logic [255:0] py);
        req_k[256*i +: 256] = k; req_px[256*i +: 256] = px; req_py[256*i +: 256] = py;
        req_use_g[i] = g; req_valid[i] = 1'b1;
    endtask

    // Returns just after the accepting edge, i.e. in the ISSUE cycle.
    task automatic do_req(input int i, input logic [255:0] k, input logic g,
                          input logic [255:0] px, input logic [255:0] py);
        set_req(i, k, g, px, py);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (req_ready[i]) break;
        end
        if (!req_ready[i]) check("accept_wait", 256'(req_ready), 256'(1 << i));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) check("rsp_wait", 256'(rsp_valid), 256'(1));
    endtask

    initial begin
        int n;
        int rl0;
        rst_n = 1'b0; req_valid = '0; req_use_g = '0; req_k = '0; req_px = '0; req_py = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_mul_rst_n", 256'(mul_rst_n), 256'(0));
        check("rst_rsp_qx", rsp_qx, 256'(0));
        check("rst_mul_k", mul_k, 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // k=1 on the generator
        stub_lat = 0;
        do_req(0, 256'd1, 1'b1, '0, '0);
        wait_rsp(n);
        check("t1_latency", 256'(n), 256'(3));
        check("t1_id", 256'(rsp_id), 256'(0));
        check("t1_qx", rsp_qx, 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798);
        check("t1_qy", rsp_qy, 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8);
        check("t1_inf", 256'(rsp_inf), 256'(0));
        @(posedge clk); #1;

        // simultaneous req0/req2 from pointer 0
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        stub_lat = 1;
        set_req(2, 256'd3, 1'b1, '0, '0);
        do_req(0, 256'd2, 1'b1, '0, '0);
        wait_rsp(n);
        check("t2a_latency", 256'(n), 256'(4));
        check("t2a_id", 256'(rsp_id), 256'(0));
        check("t2a_qx", rsp_qx, 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5);
        @(posedge clk); #1;
        do_req(2, 256'd3, 1'b1, '0, '0);
        wait_rsp(n);
        check("t2b_id", 256'(rsp_id), 256'(2));
        check("t2b_qx", rsp_qx, 256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9);
        @(posedge clk); #1;

        // k=0, with a stray done pulse during ISSUE that must be ignored
        stub_lat = 2;
        do_req(1, 256'd0, 1'b1, '0, '0);
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        wait_rsp(n);
        check("t3_latency", 256'(n), 256'(4));
        check("t3_id", 256'(rsp_id), 256'(1));
        check("t3_inf", 256'(rsp_inf), 256'(1));
        check("t3_timeout", 256'(rsp_timeout), 256'(0));
        @(posedge clk); #1;

        // multiplier never finishes
        stub_hang = 1'b1;
        rl0 = rl_cnt;
        do_req(0, 256'd9, 1'b0, 256'h1234, 256'h5678);
        wait_rsp(n);
        check("t4_latency", 256'(n), 256'(102));
        check("t4_timeout", 256'(rsp_timeout), 256'(1));
        check("t4_qx", rsp_qx, 256'(0));
        check("t4_inf", 256'(rsp_inf), 256'(0));
        @(posedge clk); #1;
        stub_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_mul_rst_pulses", 256'(rl_cnt - rl0), 256'(1));

        // consumer back-pressure with another requester waiting
        stub_lat = 0;
        rsp_ready = 1'b0;
        do_req(1, 256'd5, 1'b0, 256'hABC, 256'hDEF);
        set_req(3, 256'd6, 1'b0, 256'h77, 256'h88);
        wait_rsp(n);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_ready", 256'(req_ready), 256'(0));
            check("t5_hold_qx", rsp_qx, 256'hABC + 256'd15);
            check("t5_hold_id", 256'(rsp_id), 256'(1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        do_req(3, 256'd6, 1'b0, 256'h77, 256'h88);
        wait_rsp(n);
        check("t5_next_id", 256'(rsp_id), 256'(3));
        @(posedge clk); #1;

        // reset while waiting on the multiplier
        stub_lat = 10;
        do_req(2, 256'd7, 1'b1, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_busy", 256'(busy), 256'(0));
        check("t6_rsp_valid", 256'(rsp_valid), 256'(0));
        check("t6_mul_rst_n", 256'(mul_rst_n), 256'(0));
        check("t6_mul_k", mul_k, 256'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("t6_no_rsp", 256'(rsp_valid), 256'(0));
        end
        @(posedge clk); #1;
        stub_lat = 0;
        do_req(0, 256'd1, 1'b1, '0, '0);
        wait_rsp(n);
        check("t6_after_latency", 256'(n), 256'(3));
        check("t6_after_qx", rsp_qx, 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
